// File: rtl/imm_encoder.sv
// Immediate encoder: packs instruction fields and a full-width immediate into an
// instruction word, then queues {word, err} in a small FIFO with valid/ready handshakes.
// Optional build macro IMM_RANGE_CHECK_EN adds immediate range checking and err_count.
// Encoding assumes XLEN >= 32; bits above 31 of the output are zero.
module imm_encoder #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned OP_LEN = 7,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_types,
    input  logic [OP_LEN-1:0] in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [XLEN-1:0]   in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_instr,
    output logic              out_err
`ifdef IMM_RANGE_CHECK_EN
    ,
    output logic [15:0]       err_count
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   imm;
    logic [6:0]    opc;
    logic [31:0]   enc;
    logic          legal;
    logic          range_err;
    logic          err;
    logic          is_shift;

    logic [XLEN:0] mem_q [DEPTH];
    logic [XLEN:0] head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full;
    logic          push;
    logic          pop;

    assign imm      = in_imm[31:0];
    assign opc      = 7'(in_opcode);
    assign is_shift = (in_funct3[1:0] == 2'b01);

    // Field packing per instruction type; anything not exactly one-hot encodes as zero.
    always_comb begin
        enc       = '0;
        legal     = 1'b1;
        range_err = 1'b0;
        case (in_types)
            7'b1000000: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, opc};
            7'b0100000: begin
                if (is_shift) begin
                    enc       = {in_funct7, imm[4:0], in_rs1, in_funct3, in_rd, opc};
                    range_err = |imm[31:5];
                end else begin
                    enc       = {imm[11:0], in_rs1, in_funct3, in_rd, opc};
                    range_err = !((&imm[31:11]) || !(|imm[31:11]));
                end
            end
            7'b0010000: begin
                enc       = {imm[11:0], in_rs1, in_funct3, in_rd, opc};
                range_err = !((&imm[31:11]) || !(|imm[31:11]));
            end
            7'b0001000: begin
                enc       = {imm[11:5], in_rs2, in_rs1, in_funct3, imm[4:0], opc};
                range_err = !((&imm[31:11]) || !(|imm[31:11]));
            end
            7'b0000100: begin
                enc       = {imm[20], imm[10:1], imm[11], imm[19:12], in_rd, opc};
                range_err = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
            end
            7'b0000010: begin
                enc       = {imm[12], imm[10:5], in_rs2, in_rs1, in_funct3, imm[4:1], imm[11], opc};
                range_err = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
            end
            7'b0000001: begin
                enc       = {imm[31:12], in_rd, opc};
                range_err = |imm[11:0];
            end
            default: legal = 1'b0;
        endcase
    end

    // Error flag: illegal type always; out-of-range immediates only when checking is built in.
    always_comb begin
`ifdef IMM_RANGE_CHECK_EN
        err = !legal || range_err;
`else
        err = !legal;
`endif
    end

    // Handshake decode; a full buffer still accepts when the head drains this cycle.
    always_comb begin
        full      = (cnt_q == CW'(DEPTH));
        out_valid = (cnt_q != '0);
        in_ready  = !full || out_ready;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d     = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // FIFO occupancy and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {err, XLEN'(enc)};
        end
    end

    // Head presentation, forced to zero while empty.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        out_instr = out_valid ? head[XLEN-1:0] : '0;
        out_err   = out_valid && head[XLEN];
    end

`ifdef IMM_RANGE_CHECK_EN
    logic [15:0] err_cnt_q;

    // Saturating count of accepted requests flagged as errored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (push && err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule
